// File: rtl/fft_reorder_if.sv
// Stream bundle for fft_reorder: bit-reversed input samples in, natural-order samples out.
// Master drives the input side and observes the output side; slave is the reorder buffer.
interface fft_reorder_if #(
  parameter int width = 16,
  parameter int N     = 9
);
  logic                    en_in;
  logic [N-1:0]            cnt_in;
  logic signed [width-1:0] xin_re;
  logic signed [width-1:0] xin_im;
  logic                    en_out;
  logic [N-1:0]            cnt_out;
  logic signed [width-1:0] yout_re;
  logic signed [width-1:0] yout_im;
  logic                    err;

  modport master (
    output en_in, cnt_in, xin_re, xin_im,
    input  en_out, cnt_out, yout_re, yout_im, err
  );

  modport slave (
    input  en_in, cnt_in, xin_re, xin_im,
    output en_out, cnt_out, yout_re, yout_im, err
  );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong bit-reversal buffer: frame-end edge E -> first natural-order output at E+2, full rate, no stalls.
// Optional input-sequence checker driving err is compiled in with `define FFT_REORDER_CHECK_EN.
module fft_reorder #(
  parameter int width = 16,
  parameter int N     = 9
) (
  input  logic         clk,
  input  logic         areset,
  fft_reorder_if.slave bus
);
  localparam int DEPTH = 1 << N;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [N-1:0]         w_waddr;
  logic                 w_frame_end;
  logic                 w_rd_en;

  logic [0:0]           r_state;
  logic                 r_wbank;
  logic [N-1:0]         r_rcnt;

  logic [2*width-1:0]   r_mem [0:2*DEPTH-1];
  logic [2*width-1:0]   r_rd_dat;
  logic                 r_rd_vld;
  logic [N-1:0]         r_rd_cnt;

  logic                 r_en_out;
  logic [N-1:0]         r_cnt_out;
  logic signed [width-1:0] r_yout_re;
  logic signed [width-1:0] r_yout_im;

  always_comb begin
    w_waddr = '0;
    for (int i = 0; i < N; i++) begin
      w_waddr[i] = bus.cnt_in[N-1-i];
    end
  end

  assign w_frame_end = bus.en_in && (&bus.cnt_in);
  assign w_rd_en     = (r_state == S_READ);

  // A frame end always restarts the reader on the bank just filled, which
  // covers both the back-to-back case and the illegal early frame end.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_wbank <= 1'b0;
      r_rcnt  <= '0;
    end else if (w_frame_end) begin
      r_state <= S_READ;
      r_wbank <= ~r_wbank;
      r_rcnt  <= '0;
    end else if (r_state == S_READ) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (&r_rcnt) begin
        r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en_in) begin
      r_mem[{r_wbank, w_waddr}] <= {bus.xin_re, bus.xin_im};
    end
    if (w_rd_en) begin
      r_rd_dat <= r_mem[{~r_wbank, r_rcnt}];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rd_vld <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_cnt <= r_rcnt;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_en_out  <= 1'b0;
      r_cnt_out <= '0;
      r_yout_re <= '0;
      r_yout_im <= '0;
    end else begin
      r_en_out  <= r_rd_vld;
      r_cnt_out <= r_rd_cnt;
      if (r_rd_vld) begin
        r_yout_re <= r_rd_dat[2*width-1:width];
        r_yout_im <= r_rd_dat[width-1:0];
      end
    end
  end

  assign bus.en_out  = r_en_out;
  assign bus.cnt_out = r_cnt_out;
  assign bus.yout_re = r_yout_re;
  assign bus.yout_im = r_yout_im;

`ifdef FFT_REORDER_CHECK_EN
  // Expected position is tracked in natural order; the incoming index is
  // compared after bit reversal, and a mismatch resyncs to the sample seen.
  logic [N-1:0] r_exp;
  logic         r_err;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      if (bus.en_in) begin
        r_exp <= w_waddr + 1'b1;
        if (w_waddr != r_exp) begin
          r_err <= 1'b1;
        end
      end
      if (w_frame_end && (r_state == S_READ) && !(&r_rcnt)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder with N=3: table-driven back-to-back frames plus gap, reset and checker sequences.
module tb_fft_reorder;
  localparam int W = 16;
  localparam int NB = 3;
`ifdef FFT_REORDER_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk;
  logic areset;
  int   n_checks;
  int   n_err;

  fft_reorder_if #(.width(W), .N(NB)) bus ();

  fft_reorder #(.width(W), .N(NB)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en_in;
    logic [2:0] cnt_in;
    int         re;
    logic       exp_en;
    int         exp_cnt;
    int         exp_re;
  } vec_t;

  vec_t tbl [26];

  function automatic logic [2:0] bitrev3(input logic [2:0] c);
    return {c[0], c[1], c[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] c, input int re);
    bus.en_in  = en;
    bus.cnt_in = c;
    bus.xin_re = 16'(re);
    bus.xin_im = 16'(-re);
  endtask

  // Sends one frame in bit-reversed order; natural sample p carries base+10p.
  task automatic send_frame(input int base, input int gap_pos, input int gap_len);
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, bitrev3(3'(p)), base + 10 * p);
      tick();
      if (p == gap_pos) begin
        repeat (gap_len) begin
          drive(1'b0, 3'd0, 0);
          tick();
        end
      end
    end
    drive(1'b0, 3'd0, 0);
  endtask

  // Called right after the frame-end edge E.
  task automatic check_frame(input string tag, input int base);
    tick();
    chk($sformatf("%s_e1_en", tag), int'(bus.en_out), 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk($sformatf("%s_%0d_en", tag, n), int'(bus.en_out), 1);
      chk($sformatf("%s_%0d_cnt", tag, n), int'(bus.cnt_out), n);
      chk($sformatf("%s_%0d_re", tag, n), int'(bus.yout_re), base + 10 * n);
      chk($sformatf("%s_%0d_im", tag, n), int'(bus.yout_im), -(base + 10 * n));
    end
    tick();
    chk($sformatf("%s_tail_en", tag), int'(bus.en_out), 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    areset   = 1'b1;
    drive(1'b0, 3'd0, 0);

    for (int r = 0; r < 26; r++) begin
      tbl[r].en_in   = (r < 16);
      tbl[r].cnt_in  = (r < 16) ? bitrev3(3'(r % 8)) : 3'd0;
      tbl[r].re      = (r < 8) ? 10 * (r % 8) : 100 + 10 * (r % 8);
      tbl[r].exp_en  = (r >= 9) && (r <= 24);
      tbl[r].exp_cnt = (r >= 9) ? (r - 9) % 8 : 0;
      tbl[r].exp_re  = (r >= 9) ? ((r - 9) / 8) * 100 + 10 * tbl[r].exp_cnt : 0;
    end

    tick();
    tick();
    chk("rst_en",  int'(bus.en_out), 0);
    chk("rst_cnt", int'(bus.cnt_out), 0);
    chk("rst_re",  int'(bus.yout_re), 0);
    chk("rst_im",  int'(bus.yout_im), 0);
    chk("rst_err", int'(bus.err), 0);
    areset = 1'b0;
    tick();

    // Two frames with en_in held high: 16 unbroken output cycles.
    for (int r = 0; r < 26; r++) begin
      drive(tbl[r].en_in, tbl[r].cnt_in, tbl[r].re);
      tick();
      chk($sformatf("A%0d_en", r), int'(bus.en_out), int'(tbl[r].exp_en));
      chk($sformatf("A%0d_err", r), int'(bus.err), 0);
      if (tbl[r].exp_en) begin
        chk($sformatf("A%0d_cnt", r), int'(bus.cnt_out), tbl[r].exp_cnt);
        chk($sformatf("A%0d_re", r), int'(bus.yout_re), tbl[r].exp_re);
        chk($sformatf("A%0d_im", r), int'(bus.yout_im), -tbl[r].exp_re);
      end
    end

    // Gap of three idle cycles after the cnt_in=4 sample.
    send_frame(20, 1, 3);
    check_frame("B", 20);

    // Reset on the 4th output cycle.
    send_frame(200, -1, 0);
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("C_pre%0d_cnt", n), int'(bus.cnt_out), n);
    end
    areset = 1'b1;
    #1;
    chk("C_rst_en",  int'(bus.en_out), 0);
    chk("C_rst_cnt", int'(bus.cnt_out), 0);
    chk("C_rst_re",  int'(bus.yout_re), 0);
    chk("C_rst_im",  int'(bus.yout_im), 0);
    tick();
    areset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("C_quiet%0d", k), int'(bus.en_out), 0);
    end
    send_frame(300, -1, 0);
    check_frame("C2", 300);

    // Partial frame discarded by reset, then a clean frame from cnt_in=0.
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, bitrev3(3'(p)), 400 + 10 * p);
      tick();
    end
    drive(1'b0, 3'd0, 0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("D_quiet%0d", k), int'(bus.en_out), 0);
    end
    send_frame(500, -1, 0);
    check_frame("D", 500);
    chk("D_err", int'(bus.err), 0);

    // Index sequence 0,4,2,2: the repeated 2 is out of order.
    drive(1'b1, 3'd0, 0);
    tick();
    chk("E_err0", int'(bus.err), 0);
    drive(1'b1, 3'd4, 0);
    tick();
    chk("E_err4", int'(bus.err), 0);
    drive(1'b1, 3'd2, 0);
    tick();
    chk("E_err2a", int'(bus.err), 0);
    drive(1'b1, 3'd2, 0);
    tick();
    chk("E_err2b", int'(bus.err), ERR_EXP);
    drive(1'b0, 3'd0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("E_sticky%0d", k), int'(bus.err), ERR_EXP);
    end
    areset = 1'b1;
    tick();
    chk("E_rst_err", int'(bus.err), 0);
    areset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
